// File: rtl/vga_sync_gen.sv
// Raster timing generator: X/Y counters with registered DE, HSYNC, VSYNC, PIX_CE, FRAME_START.
// Optional VGA_SYNC_PIPE_EN delays DE/HSYNC/VSYNC by one CE tick.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CE,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          DE,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          PIX_CE,
  output logic          FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

  logic [CW-1:0] x_nxt;
  logic [CW-1:0] y_nxt;
  logic          h_wrap;
  logic          de_nxt;
  logic          hs_nxt;
  logic          vs_nxt;
  logic          de_r;
  logic          hs_r;
  logic          vs_r;

  // Sync/DE decode from the next position keeps them aligned with X/Y
  always_comb begin
    h_wrap = (X == H_LAST);
    x_nxt  = h_wrap ? '0 : X + CW'(1);
    y_nxt  = Y;
    if (h_wrap)
      y_nxt = (Y == V_LAST) ? '0 : Y + CW'(1);
    de_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    hs_nxt = (x_nxt >= HS_BEG && x_nxt < HS_END)
           ? SYNC_POL : ~SYNC_POL;
    vs_nxt = (y_nxt >= VS_BEG && y_nxt < VS_END)
           ? SYNC_POL : ~SYNC_POL;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      X           <= H_LAST;
      Y           <= V_LAST;
      de_r        <= 1'b0;
      hs_r        <= ~SYNC_POL;
      vs_r        <= ~SYNC_POL;
      PIX_CE      <= 1'b0;
      FRAME_START <= 1'b0;
    end else if (CE) begin
      X           <= x_nxt;
      Y           <= y_nxt;
      de_r        <= de_nxt;
      hs_r        <= hs_nxt;
      vs_r        <= vs_nxt;
      PIX_CE      <= de_nxt;
      FRAME_START <= (x_nxt == '0) && (y_nxt == '0);
    end else begin
      PIX_CE      <= 1'b0;
      FRAME_START <= 1'b0;
    end
  end

`ifdef VGA_SYNC_PIPE_EN
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      DE    <= 1'b0;
      HSYNC <= ~SYNC_POL;
      VSYNC <= ~SYNC_POL;
    end else if (CE) begin
      DE    <= de_r;
      HSYNC <= hs_r;
      VSYNC <= vs_r;
    end
  end
`else
  assign DE    = de_r;
  assign HSYNC = hs_r;
  assign VSYNC = vs_r;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen: a small-raster instance and a
// default 640x480 instance, both checked against a behavioural model.
module tb_vga_sync_gen;

  localparam int HA = 40, HF = 4, HW = 6, HB = 10;
  localparam int VA = 30, VF = 2, VW = 2, VB = 4;
  localparam int HT = HA + HF + HW + HB;
  localparam int VT = VA + VF + VW + VB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b0;

  logic [9:0] sx, sy, dx, dy;
  logic sde, shs, svs, spce, sfs;
  logic dde, dhs, dvs, dpce, dfs;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VW), .V_BP(VB),
    .SYNC_POL(1'b0), .CW(10)
  ) u_small (
    .CLK(clk), .RESET(rst_n), .CE(ce),
    .X(sx), .Y(sy), .DE(sde), .HSYNC(shs), .VSYNC(svs),
    .PIX_CE(spce), .FRAME_START(sfs)
  );

  vga_sync_gen u_dflt (
    .CLK(clk), .RESET(rst_n), .CE(ce),
    .X(dx), .Y(dy), .DE(dde), .HSYNC(dhs), .VSYNC(dvs),
    .PIX_CE(dpce), .FRAME_START(dfs)
  );

  typedef struct {
    int x; int y;
    bit de; bit hs; bit vs; bit pce; bit fs;
    bit pde; bit phs; bit pvs;
  } mdl_t;

  int errors = 0;
  int checks = 0;
  int ticks = 0;
  int fs_tick = 0;
  int pce_cnt = 0;
  int dhs_lo = 0;
  bit have_prev = 0;
  mdl_t ms, md;
  logic [24:0] q_s[$];
  logic [24:0] q_d[$];

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic mdl_t mdl_rst(input int ht, input int vt);
    mdl_t m;
    m.x = ht - 1; m.y = vt - 1;
    m.de = 0; m.hs = 1; m.vs = 1; m.pce = 0; m.fs = 0;
    m.pde = 0; m.phs = 1; m.pvs = 1;
    return m;
  endfunction

  function automatic mdl_t mdl_step(
    input mdl_t m, input bit c,
    input int ha, input int hf, input int hw, input int hb,
    input int va, input int vf, input int vw, input int vb);
    mdl_t n;
    int ht, vt;
    n = m;
    ht = ha + hf + hw + hb;
    vt = va + vf + vw + vb;
    if (!c) begin
      n.pce = 0; n.fs = 0;
      return n;
    end
    n.pde = m.de; n.phs = m.hs; n.pvs = m.vs;
    if (m.x == ht - 1) begin
      n.x = 0;
      n.y = (m.y == vt - 1) ? 0 : m.y + 1;
    end else begin
      n.x = m.x + 1;
    end
    n.de  = (n.x < ha) && (n.y < va);
    n.hs  = !(n.x >= ha + hf && n.x < ha + hf + hw);
    n.vs  = !(n.y >= va + vf && n.y < va + vf + vw);
    n.pce = n.de;
    n.fs  = (n.x == 0) && (n.y == 0);
    return n;
  endfunction

  function automatic logic [24:0] mdl_obs(input mdl_t m);
`ifdef VGA_SYNC_PIPE_EN
    return {10'(m.x), 10'(m.y), m.pde, m.phs, m.pvs, m.pce, m.fs};
`else
    return {10'(m.x), 10'(m.y), m.de, m.hs, m.vs, m.pce, m.fs};
`endif
  endfunction

  task automatic cyc(input bit c);
    logic [24:0] e;
    @(negedge clk);
    ce = c;
    ms = mdl_step(ms, c, HA, HF, HW, HB, VA, VF, VW, VB);
    md = mdl_step(md, c, 640, 16, 96, 48, 480, 10, 2, 33);
    q_s.push_back(mdl_obs(ms));
    q_d.push_back(mdl_obs(md));
    @(posedge clk);
    #1;
    e = q_s.pop_front();
    chk("small", {7'd0, sx, sy, sde, shs, svs, spce, sfs}, {7'd0, e});
    e = q_d.pop_front();
    chk("dflt", {7'd0, dx, dy, dde, dhs, dvs, dpce, dfs}, {7'd0, e});
    if (c) ticks++;
    if (c && !dhs) dhs_lo++;
    if (sfs) begin
      if (have_prev) begin
        chk("fs_period", ticks - fs_tick, HT * VT);
        chk("de_frame", pce_cnt, HA * VA);
      end
      have_prev = 1;
      fs_tick = ticks;
      pce_cnt = 0;
    end
    if (spce) pce_cnt++;
  endtask

  initial begin
    ms = mdl_rst(HT, VT);
    md = mdl_rst(800, 525);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", dx, 799);
    chk("rst_y", dy, 524);
    chk("rst_de", dde, 0);
    chk("rst_hs", dhs, 1);
    chk("rst_vs", dvs, 1);
    chk("rst_pce", dpce, 0);
    chk("rst_fs", dfs, 0);
    chk("rst_small", {sx, sy}, {10'(HT - 1), 10'(VT - 1)});

    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    chk("first_xy", {dx, dy}, 20'd0);
    chk("first_fs", dfs, 1);
    repeat (639) cyc(1);
    chk("x639", dx, 639);
    repeat (160) cyc(1);
    chk("line_end", {dx, dy}, {10'd799, 10'd0});
    chk("hs_lo_line", dhs_lo, 96);
    cyc(1);
    chk("wrap_y", {dx, dy}, {10'd0, 10'd1});
    repeat (2 * HT * VT + 20 - 801) cyc(1);

    repeat (2 * HT * 2) begin
      cyc(1);
      cyc(0);
    end

    repeat (20 * HT + 7) cyc(1);
    cyc(0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_small", {sx, sy}, {10'(HT - 1), 10'(VT - 1)});
    chk("arst_sync", {sde, shs, svs, spce, sfs}, 5'b01100);
    chk("arst_dflt", {dx, dy}, {10'd799, 10'd524});
    ms = mdl_rst(HT, VT);
    md = mdl_rst(800, 525);
    have_prev = 0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    chk("restart_xy", {sx, sy}, 20'd0);
    chk("restart_fs", sfs, 1);
    repeat (HT * VT + 5) cyc(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
